// File: rtl/dmem_master_pkg.sv
// Shared types and constants for the data-memory initiator.
package dmem_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam int unsigned DEPTH_WORDS_DEF = 64;
  localparam int unsigned LANE_W          = 8;

  // Big-endian byte map: offset 0 is rd[31:24], offset 3 is rd[7:0].
  function automatic logic [4:0] lane_shift(input logic [1:0] off);
    return {~off, 3'b000};
  endfunction

endpackage

// File: rtl/dmem_master_if.sv
// Core request/response channels plus data-memory pins for dmem_master.
interface dmem_master_if #(parameter int unsigned AW = 32);
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic          req_byte;
  logic          req_signed;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          dmem_we;
  logic          dmem_bytemode;
  logic [AW-1:0] dmem_a;
  logic [31:0]   dmem_wd;
  logic [31:0]   dmem_rd;

  modport master (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output dmem_we, dmem_bytemode, dmem_a, dmem_wd,
    input  dmem_rd
  );

  modport slave (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  dmem_we, dmem_bytemode, dmem_a, dmem_wd,
    output dmem_rd
  );
endinterface

// File: rtl/dmem_master_load_extract.sv
// Byte-lane select and sign/zero extension of a memory read word.
module dmem_master_load_extract
  import dmem_master_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  off,
  input  logic        is_byte,
  input  logic        is_signed,
  output logic [31:0] res
);
  logic [31:0]       sh;
  logic [LANE_W-1:0] b;

  assign sh  = rd >> lane_shift(off);
  assign b   = sh[LANE_W-1:0];
  assign res = is_byte ? {{(32-LANE_W){is_signed & b[LANE_W-1]}}, b} : rd;
endmodule

// File: rtl/dmem_master.sv
// Data-memory initiator: one-cycle access per request, checked for alignment
// and range, result held on a valid/ready response channel.
module dmem_master
  import dmem_master_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
  parameter int unsigned AW          = 32
) (
  input  logic            clk,
  input  logic            reset,
  dmem_master_if.master   bus
);
  localparam logic [AW-3:0] DEPTH_LIM = (AW-2)'(DEPTH_WORDS);

  state_t        state;
  logic          held_write, held_byte, held_signed, held_err;
  logic [AW-1:0] held_addr;
  logic [31:0]   held_wdata;
  logic          we_q, rsp_valid_q, rsp_err_q;
  logic [31:0]   rsp_rdata_q;
  logic [31:0]   ext;
  logic          accept, req_err;

  assign bus.req_ready = (state == IDLE) | ((state == RESP) & bus.rsp_ready);
  assign accept        = bus.req_valid & bus.req_ready;
  assign req_err       = (!bus.req_byte && (bus.req_addr[1:0] != 2'b00)) ||
                         (bus.req_addr[AW-1:2] >= DEPTH_LIM);

  dmem_master_load_extract u_ext (
    .rd        (bus.dmem_rd),
    .off       (held_addr[1:0]),
    .is_byte   (held_byte),
    .is_signed (held_signed),
    .res       (ext)
  );

  // we_q is armed at accept so it is high for exactly the ACCESS cycle and
  // is cleared by the asynchronous reset before the next edge can write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      held_write  <= 1'b0;
      held_byte   <= 1'b0;
      held_signed <= 1'b0;
      held_err    <= 1'b0;
      held_addr   <= '0;
      held_wdata  <= '0;
      we_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (accept) begin
        held_write  <= bus.req_write;
        held_byte   <= bus.req_byte;
        held_signed <= bus.req_signed;
        held_err    <= req_err;
        held_addr   <= bus.req_addr;
        held_wdata  <= bus.req_wdata;
        we_q        <= bus.req_write & ~req_err;
      end
      case (state)
        IDLE: if (accept) state <= ACCESS;
        ACCESS: begin
          we_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= held_err;
          rsp_rdata_q <= (!held_write && !held_err) ? ext : 32'd0;
          state       <= RESP;
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= accept ? ACCESS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.dmem_we       = we_q;
  assign bus.dmem_a        = held_addr;
  assign bus.dmem_bytemode = held_byte;
  assign bus.dmem_wd       = held_wdata;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_rdata     = rsp_rdata_q;
  assign bus.rsp_err       = rsp_err_q;
endmodule

// File: tb/tb_dmem_master.sv
// Directed bench for dmem_master against a 64-word big-endian memory model.
module tb_dmem_master;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  dmem_master_if #(.AW(32)) bus ();
  dmem_master #(.DEPTH_WORDS(64), .AW(32)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [31:0] mem [64];
  logic        poke_en = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;

  assign bus.dmem_rd = mem[bus.dmem_a[7:2]];

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    else if (bus.dmem_we) begin
      if (!bus.dmem_bytemode) mem[bus.dmem_a[7:2]] <= bus.dmem_wd;
      else case (bus.dmem_a[1:0])
        2'd0: mem[bus.dmem_a[7:2]][31:24] <= bus.dmem_wd[7:0];
        2'd1: mem[bus.dmem_a[7:2]][23:16] <= bus.dmem_wd[7:0];
        2'd2: mem[bus.dmem_a[7:2]][15:8]  <= bus.dmem_wd[7:0];
        default: mem[bus.dmem_a[7:2]][7:0] <= bus.dmem_wd[7:0];
      endcase
    end
  end

  task automatic poke(input logic [5:0] idx, input logic [31:0] val);
    poke_idx = idx; poke_val = val; poke_en = 1'b1;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  // One full transaction from IDLE; lat counts cycles from accept to rsp_valid.
  task automatic xact(input logic w, input logic b, input logic s,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rd, output logic e,
                      output int lat, output int wecnt, output logic [31:0] acc_a);
    bus.req_write = w; bus.req_byte = b; bus.req_signed = s;
    bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_write = ~w; bus.req_byte = ~b; bus.req_signed = ~s;
    bus.req_addr = ~addr; bus.req_wdata = ~wdata;
    lat = 1; wecnt = 0; acc_a = bus.dmem_a;
    while (!bus.rsp_valid && lat < 20) begin
      wecnt += int'(bus.dmem_we);
      @(posedge clk); #1;
      lat++;
    end
    rd = bus.rsp_rdata; e = bus.rsp_err;
    wecnt += int'(bus.dmem_we);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    wecnt += int'(bus.dmem_we);
  endtask

  task automatic test_reset();
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0 0 0", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata); end
    checks++; if (bus.dmem_we !== 1'b0 || bus.dmem_bytemode !== 1'b0 || bus.dmem_a !== 32'd0 || bus.dmem_wd !== 32'd0) begin
      errors++; $display("FAIL reset_dmem got we=%b bm=%b a=%h wd=%h want all 0", bus.dmem_we, bus.dmem_bytemode, bus.dmem_a, bus.dmem_wd); end
  endtask

  task automatic test_word();
    logic [31:0] rd, a; logic e; int lat, wec;
    poke(6'd4, 32'h0);
    xact(1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, rd, e, lat, wec, a);
    checks++; if (wec !== 1) begin errors++; $display("FAIL sw_we_cycles got %0d want 1", wec); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL sw_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'd0 || e !== 1'b0) begin errors++; $display("FAIL sw_rsp got d=%h e=%b want 0 0", rd, e); end
    checks++; if (a !== 32'h10) begin errors++; $display("FAIL sw_addr got %h want 00000010", a); end
    checks++; if (mem[4] !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_mem got %h want deadbeef", mem[4]); end
    xact(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'hDEADBEEF || e !== 1'b0) begin errors++; $display("FAIL lw_rsp got d=%h e=%b want deadbeef 0", rd, e); end
    checks++; if (lat !== 2 || wec !== 0) begin errors++; $display("FAIL lw_timing got lat=%0d we=%0d want 2 0", lat, wec); end
  endtask

  task automatic test_byte();
    logic [31:0] rd, a; logic e; int lat, wec;
    poke(6'd4, 32'h11223344);
    xact(1'b1, 1'b1, 1'b0, 32'h13, 32'hAAAAAA80, rd, e, lat, wec, a);
    checks++; if (mem[4] !== 32'h11223380 || wec !== 1) begin errors++; $display("FAIL sb_mem got %h we=%0d want 11223380 1", mem[4], wec); end
    xact(1'b0, 1'b1, 1'b1, 32'h13, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'hFFFFFF80 || e !== 1'b0) begin errors++; $display("FAIL lb_13 got %h e=%b want ffffff80 0", rd, e); end
    xact(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_13 got %h want 00000080", rd); end
    xact(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'h00000011) begin errors++; $display("FAIL lbu_10 got %h want 00000011", rd); end
    xact(1'b0, 1'b1, 1'b1, 32'h11, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'h00000022) begin errors++; $display("FAIL lb_11 got %h want 00000022", rd); end
    xact(1'b0, 1'b0, 1'b1, 32'h10, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'h11223380) begin errors++; $display("FAIL lw_signed got %h want 11223380", rd); end
  endtask

  task automatic test_misaligned();
    logic [31:0] rd, a; logic e; int lat, wec;
    poke(6'd3, 32'hCAFEF00D);
    xact(1'b1, 1'b0, 1'b0, 32'h0E, 32'h12345678, rd, e, lat, wec, a);
    checks++; if (e !== 1'b1 || rd !== 32'd0 || wec !== 0) begin errors++; $display("FAIL sw_misal got e=%b d=%h we=%0d want 1 0 0", e, rd, wec); end
    checks++; if (mem[3] !== 32'hCAFEF00D) begin errors++; $display("FAIL sw_misal_mem got %h want cafef00d", mem[3]); end
    xact(1'b0, 1'b0, 1'b0, 32'h11, 32'h0, rd, e, lat, wec, a);
    checks++; if (e !== 1'b1 || rd !== 32'd0 || lat !== 2) begin errors++; $display("FAIL lw_misal got e=%b d=%h lat=%0d want 1 0 2", e, rd, lat); end
  endtask

  task automatic test_range();
    logic [31:0] rd, a; logic e; int lat, wec;
    poke(6'd63, 32'h89ABCDEF);
    poke(6'd0, 32'h01020304);
    xact(1'b0, 1'b0, 1'b0, 32'hFC, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'h89ABCDEF || e !== 1'b0) begin errors++; $display("FAIL lw_last got %h e=%b want 89abcdef 0", rd, e); end
    xact(1'b0, 1'b1, 1'b1, 32'hFF, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'hFFFFFFEF || e !== 1'b0) begin errors++; $display("FAIL lb_last got %h e=%b want ffffffef 0", rd, e); end
    xact(1'b0, 1'b0, 1'b0, 32'h100, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'd0 || e !== 1'b1) begin errors++; $display("FAIL lw_oor got %h e=%b want 0 1", rd, e); end
    xact(1'b1, 1'b0, 1'b0, 32'h100, 32'hFFFFFFFF, rd, e, lat, wec, a);
    checks++; if (e !== 1'b1 || wec !== 0 || mem[0] !== 32'h01020304) begin
      errors++; $display("FAIL sw_oor got e=%b we=%0d mem0=%h want 1 0 01020304", e, wec, mem[0]); end
  endtask

  task automatic test_back_to_back();
    poke(6'd4, 32'hA1B2C3D4);
    poke(6'd5, 32'h0);
    bus.req_write = 1'b0; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h10; bus.req_wdata = 32'h0; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_write = 1'b1; bus.req_addr = 32'h14; bus.req_wdata = 32'h55667788;
    @(posedge clk); #1;
    // Change memory under the held response: the captured result must not move.
    poke_idx = 6'd4; poke_val = 32'h0; poke_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hA1B2C3D4 || bus.req_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%h rdy=%b want 1 a1b2c3d4 0", i, bus.rsp_valid, bus.rsp_rdata, bus.req_ready); end
      @(posedge clk); #1;
      poke_en = 1'b0;
    end
    bus.rsp_ready = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", bus.req_ready); end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b0;
    checks++; if (bus.dmem_we !== 1'b1 || bus.dmem_a !== 32'h14 || bus.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL b2b_access got we=%b a=%h v=%b want 1 00000014 0", bus.dmem_we, bus.dmem_a, bus.rsp_valid); end
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_rdata !== 32'd0 || mem[5] !== 32'h55667788) begin
      errors++; $display("FAIL b2b_rsp got v=%b e=%b d=%h mem5=%h want 1 0 0 55667788", bus.rsp_valid, bus.rsp_err, bus.rsp_rdata, mem[5]); end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, a; logic e; int lat, wec;
    poke(6'd8, 32'h0BADBEEF);
    bus.req_write = 1'b1; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h20; bus.req_wdata = 32'hFFFFFFFF; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++; if (bus.dmem_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we got %b want 1", bus.dmem_we); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.dmem_we !== 1'b0) begin errors++; $display("FAIL rst_async_we got %b want 0", bus.dmem_we); end
    @(posedge clk); #1;
    checks++; if (mem[8] !== 32'h0BADBEEF) begin errors++; $display("FAIL rst_mem got %h want 0badbeef", mem[8]); end
    test_reset();
    reset = 1'b0;
    xact(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, rd, e, lat, wec, a);
    checks++; if (rd !== 32'h0BADBEEF || lat !== 2) begin errors++; $display("FAIL rst_after got %h lat=%0d want 0badbeef 2", rd, lat); end
    // Pending response dropped by reset.
    bus.req_write = 1'b0; bus.req_addr = 32'h20; bus.req_valid = 1'b1; bus.rsp_ready = 1'b0;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 32'd0) begin
      errors++; $display("FAIL rst_resp got v=%b d=%h want 0 0", bus.rsp_valid, bus.rsp_rdata); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_resp_idle got v=%b rdy=%b want 0 1", bus.rsp_valid, bus.req_ready); end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_byte = 1'b0; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    test_word();
    test_byte();
    test_misaligned();
    test_range();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
